// File: rtl/instr_fetch_if.sv
// Bundle of handshake, memory and status signals between the instruction
// fetch controller and its environment (instruction memory + processor).
interface instr_fetch_if #(
  parameter int ADDR_W = 5
);
  logic              start;
  logic              stop;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;
  logic [15:0]       din;
  logic              run;
  logic              done;
  logic              busy;
  logic              halted;
  logic              fault;
  logic [15:0]       instr_count;

  // Controller side: drives the memory address and all status outputs.
  modport master (
    input  start, stop, mem_data, done,
    output mem_addr, din, run, busy, halted, fault, instr_count
  );

  // Environment side: supplies control levels, memory data and Done.
  modport slave (
    output start, stop, mem_data, done,
    input  mem_addr, din, run, busy, halted, fault, instr_count
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch controller: walks a program in an asynchronous
// instruction memory, hands each word to the processor and waits for its
// Done pulse. Handles two-word mvi instructions, graceful stop, end of
// program (HALT) and watchdog / range faults (FAULT).
module instr_fetch #(
  parameter int ADDR_W    = 5,
  parameter int LAST_ADDR = 31,
  parameter int TIMEOUT   = 15
) (
  input  logic            clk_i,
  input  logic            resetn_i,
  instr_fetch_if.master   bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_HALT  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(LAST_ADDR);
  // Last counter value before the watchdog fires; the EXEC cycle that sees
  // this value with no Done is the TIMEOUT-th idle EXEC cycle.
  localparam logic [TMO_W-1:0]  TMO_LIM = TMO_W'(TIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              stop_req_q, stop_req_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  logic is_mvi;
  assign is_mvi = (bus.mem_data[8:6] == 3'b001);

  // Next-state and datapath decisions for the fetch/execute sequence.
  always_comb begin
    // NOTE: every next-state signal gets a hold default first, so no path
    // through the case below can leave one unassigned and infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    stop_req_d = stop_req_q;
    tmo_d      = tmo_q;

    unique case (state_q)
      S_IDLE: begin
        // Stop takes priority over Start while idle.
        if (bus.start && !bus.stop) begin
          pc_d       = '0;
          cnt_d      = '0;
          stop_req_d = 1'b0;
          state_d    = S_FETCH;
        end
      end

      S_FETCH: begin
        tmo_d = '0;
        if (bus.stop) stop_req_d = 1'b1;
        if (is_mvi) begin
          // The immediate lives in the next word; there is none after the
          // final program word.
          if (pc_q == LAST_PC) begin
            state_d = S_FAULT;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = S_EXEC;
          end
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        if (bus.stop) stop_req_d = 1'b1;
        if (bus.done) begin
          cnt_d = cnt_q + 16'd1;
          if (pc_q == LAST_PC) begin
            state_d = S_HALT;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = (stop_req_q || bus.stop) ? S_IDLE : S_FETCH;
          end
        end else if (tmo_q == TMO_LIM) begin
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      // HALT and FAULT are sticky until reset.
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;

      default: state_d = S_FAULT;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!resetn_i) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      cnt_q      <= '0;
      stop_req_q <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      stop_req_q <= stop_req_d;
      tmo_q      <= tmo_d;
    end
  end

  assign bus.mem_addr    = pc_q;
  assign bus.din         = bus.mem_data;
  assign bus.run         = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign bus.busy        = !((state_q == S_IDLE) || (state_q == S_HALT) ||
                             (state_q == S_FAULT));
  assign bus.halted      = (state_q == S_HALT);
  assign bus.fault       = (state_q == S_FAULT);
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: randomized Start/Stop/Done/reset
// stimulus and program contents, compared each cycle against a behavioural
// model of the fetch controller.
module tb_instr_fetch;
  localparam int ADDR_W    = 5;
  localparam int LAST_ADDR = 31;
  localparam int TIMEOUT   = 15;

  logic clk = 1'b0;
  logic resetn;

  instr_fetch_if #(.ADDR_W(ADDR_W)) bus ();

  instr_fetch #(
    .ADDR_W   (ADDR_W),
    .LAST_ADDR(LAST_ADDR),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk_i   (clk),
    .resetn_i(resetn),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:LAST_ADDR];
  assign bus.mem_data = mem[bus.mem_addr];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: what the controller is doing and its visible state.
  typedef enum {M_IDLE, M_FETCH, M_EXEC, M_HALT, M_FAULT} mode_t;
  mode_t m_mode;
  int    m_pc;
  int    m_cnt;
  int    m_wait;
  bit    m_stop;

  task automatic model_step(input bit rstn, input bit start, input bit stop,
                            input bit done);
    logic [15:0] w;
    if (!rstn) begin
      m_mode = M_IDLE; m_pc = 0; m_cnt = 0; m_wait = 0; m_stop = 0;
      return;
    end
    case (m_mode)
      M_IDLE: if (start && !stop) begin
        m_pc = 0; m_cnt = 0; m_stop = 0; m_mode = M_FETCH;
      end
      M_FETCH: begin
        w = mem[m_pc];
        m_wait = 0;
        if (stop) m_stop = 1;
        if (w[8:6] == 3'b001) begin
          if (m_pc == LAST_ADDR) m_mode = M_FAULT;
          else begin m_pc = m_pc + 1; m_mode = M_EXEC; end
        end else begin
          m_mode = M_EXEC;
        end
      end
      M_EXEC: begin
        if (stop) m_stop = 1;
        if (done) begin
          m_cnt = (m_cnt + 1) % 65536;
          if (m_pc == LAST_ADDR) m_mode = M_HALT;
          else begin
            m_pc = m_pc + 1;
            m_mode = m_stop ? M_IDLE : M_FETCH;
          end
        end else begin
          m_wait = m_wait + 1;
          if (m_wait == TIMEOUT) m_mode = M_FAULT;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_outputs();
    bit active;
    active = (m_mode == M_FETCH) || (m_mode == M_EXEC);
    check("mem_addr",    32'(bus.mem_addr),    32'(m_pc));
    check("din",         32'(bus.din),         32'(mem[m_pc]));
    check("run",         32'(bus.run),         32'(active));
    check("busy",        32'(bus.busy),        32'(active));
    check("halted",      32'(bus.halted),      32'(m_mode == M_HALT));
    check("fault",       32'(bus.fault),       32'(m_mode == M_FAULT));
    check("instr_count", 32'(bus.instr_count), 32'(m_cnt));
  endtask

  // One clock: check the state settled by the previous edge, then apply
  // new inputs and advance the model alongside the DUT.
  task automatic tick(input bit rstn, input bit start, input bit stop,
                      input bit done);
    @(negedge clk);
    check_outputs();
    resetn    = rstn;
    bus.start = start;
    bus.stop  = stop;
    bus.done  = done;
    @(posedge clk);
    model_step(rstn, start, stop, done);
  endtask

  task automatic run_phase(input int cycles, input int p_done, input int p_stop,
                           input int p_start, input int p_rst);
    for (int i = 0; i < cycles; i++)
      tick($urandom_range(99) >= p_rst, $urandom_range(99) < p_start,
           $urandom_range(99) < p_stop, $urandom_range(99) < p_done);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) tick(1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic fill_mem(input int p_mvi);
    logic [15:0] w;
    for (int i = 0; i <= LAST_ADDR; i++) begin
      w = 16'($urandom);
      if ($urandom_range(99) < p_mvi) w[8:6] = 3'b001;
      else if (w[8:6] == 3'b001)      w[8:6] = 3'b000;
      mem[i] = w;
    end
  endtask

  task automatic fill_mv();
    for (int i = 0; i <= LAST_ADDR; i++) mem[i] = 16'h0008;
  endtask

  initial begin
    fill_mv();
    resetn    = 1'b0;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.done  = 1'b0;
    @(posedge clk);
    model_step(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state, then Start and Stop both high while idle.
    do_reset();
    run_phase(10, 50, 100, 100, 0);

    // Straight-line program run to HALT at the last address, then sticky.
    run_phase(200, 50, 0, 100, 0);
    do_reset();

    // Done withheld: watchdog fault, sticky under Start.
    run_phase(40, 0, 0, 100, 0);
    do_reset();

    // mvi in the final word faults after its FETCH.
    mem[LAST_ADDR] = 16'h0040;
    run_phase(90, 100, 0, 100, 0);
    do_reset();

    // Random programs with mvi, random Done/Stop/Start and reset.
    for (int r = 0; r < 6; r++) begin
      fill_mem(25);
      run_phase(400, 45, 3, 60, 1);
      do_reset();
    end

    // Frequent stop requests.
    fill_mem(20);
    run_phase(400, 50, 20, 80, 1);

    @(negedge clk);
    check_outputs();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
